keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Upstream front end of the counting machine.
- Scans a 4x3 matrix keypad, synchronises and debounces the row returns, and encodes the pressed key.
- Outputs a one-clock press strobe, a debounced held level, and the debounced `star_pressed` level that drives the downstream counter's star input.
- The `key_pressed` level serves as the counter's advance clock; its falling edge marks a debounced release.

Parameters:
- SCAN_DIV, 1000, clk cycles per scan tick (column dwell time); minimum 4.
- DEBOUNCE_SCANS, 4, consecutive matching ticks required to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- row_n  in  4  keypad rows, active-low, asynchronous to clk.
- col_n  out  3  column drive, one-hot active-low.
- key_code  out  4  last accepted key: 0-9 = digits, 4'hA = *, 4'hB = #.
- key_valid  out  1  one-clk pulse when a press is accepted.
- key_release  out  1  one-clk pulse when a release is accepted.
- key_pressed  out  1  debounced level: high from acceptance until release acceptance.
- star_pressed  out  1  key_pressed AND key_code==4'hA (registered).

Behaviour:
- Reset values:
  - col_n=3'b110 (column 0 driven).
  - key_code=0; key_valid, key_release, key_pressed and star_pressed all 0.
  - State SCAN; divider and debounce counter 0; synchronisers load 4'hF.
- Synchronisation:
  - row_n passes through 2 flops before use.
  - Only the synced value is sampled, and only on a tick.
- Tick generation:
  - Divider counts 0..SCAN_DIV-1 and wraps.
  - tick=1 for the cycle when divider==SCAN_DIV-1.
  - The divider free-runs in all states.
- Key map (row r, col c):
  - r0 = 1 2 3
  - r1 = 4 5 6
  - r2 = 7 8 9
  - r3 = * 0 #
- Multiple rows low: the lowest row index wins; other rows are ignored for that key.
- SCAN state:
  - On a tick with all synced rows high, advance the column 0->1->2->0.
  - On a tick with any row low, latch (row, col), debounce count=1, go DEBOUNCE.
  - The column is frozen thereafter.
  - If DEBOUNCE_SCANS==1, go directly to the accept action instead.
- DEBOUNCE state:
  - On a tick where the latched row is still low: increment the count.
    - When count reaches DEBOUNCE_SCANS, accept: register key_code, pulse key_valid, set key_pressed, go HELD.
    - key_valid and key_code update in the same cycle.
  - On a tick where the latched row is high: count=0, advance the column, go SCAN.
    - No output change.
- HELD state:
  - The column stays frozen.
  - On a tick where the latched row is high: count=1, go RELEASE.
    - If DEBOUNCE_SCANS==1, release immediately.
- RELEASE state:
  - On a tick where the latched row is low: count=0, go HELD.
    - No pulse; key_pressed stays 1.
  - On a tick where the latched row is high: increment the count.
    - When count reaches DEBOUNCE_SCANS: clear key_pressed, pulse key_release, advance the column, go SCAN.
- Output rules:
  - star_pressed follows key_pressed/key_code with 1-cycle register latency.
  - A second key pressed while one is HELD is ignored, because only the latched row/column is observed.
  - key_code holds its last value after release.
- Reset mid-operation: immediately returns to reset values, with no pulses.
  - A key held through reset deassertion is re-acquired from SCAN and produces a fresh key_valid.
- Press latency (row low at pins to key_valid) is at most 2 clk + (DEBOUNCE_SCANS + 3)·SCAN_DIV.

Decomposition:
- Shared package holds:
  - Key code constants: KEY_STAR=4'hA, KEY_HASH=4'hB.
  - State enum: SCAN, DEBOUNCE, HELD, RELEASE.
  - The row/column-to-code lookup function.
- One sub-module: scan_tick_gen (parameter SCAN_DIV; outputs tick).
- The synchroniser and FSM stay in keypad_scanner.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3):
- Idle after reset -> col_n cycles 110, 101, 011, 110 every 4 clk; key_valid never asserts.
- Hold row_n=4'b1110 (row 0) while col_n==101, stable for 40 clk -> one key_valid pulse; key_code=2; key_pressed=1.
- Release that key -> key_release pulse after 3 high ticks; key_pressed=0; key_code stays 2; scanning resumes on column 2.
- Press * (row 3, col 0) -> key_code=4'hA; star_pressed=1 one cycle after key_pressed; release -> star_pressed=0.
- Bounce: row low for 1 tick, high for 1 tick during DEBOUNCE -> no key_valid; FSM returns to SCAN. Bounce high for 1 tick during HELD -> no key_release; key_pressed stays 1.
- Assert reset while HELD on 5 -> all outputs 0 within the reset cycle; after deassertion with the key still held -> new key_valid with key_code=5.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: key codes, FSM states and the
// matrix position to key code mapping.
package keypad_scanner_pkg;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  // Keypad layout: rows 0-2 carry digits 1-9, row 3 is "* 0 #".
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    unique case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row wins when several rows are pulled low.
  function automatic logic [1:0] first_low_row(input logic [3:0] rows_n);
    logic [1:0] row;
    if (!rows_n[0])      row = 2'd0;
    else if (!rows_n[1]) row = 2'd1;
    else if (!rows_n[2]) row = 2'd2;
    else                 row = 2'd3;
    return row;
  endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// Free-running divider producing a one-cycle scan tick every SCAN_DIV clocks.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_q;
  logic [CW-1:0] div_d;

  assign tick_o = (div_q == DIV_MAX);

  always_comb begin
    div_d = tick_o ? '0 : div_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) div_q <= '0;
    else         div_q <= div_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, row synchronisation, per-tick
// debounce of press and release, and key encoding with registered strobes.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_pressed,
  output logic       star_pressed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam bit SINGLE_SCAN = (DEBOUNCE_SCANS == 1);

  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  state_e           state_q;
  logic [1:0]       col_q;
  logic [1:0]       row_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_release_q;
  logic             key_pressed_q;
  logic             star_q;

  logic             tick;
  logic             any_low;
  logic [1:0]       hit_row;
  logic             latched_low;
  logic [1:0]       col_next;
  logic [CNT_W-1:0] cnt_inc;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk_i  (clk),
    .reset_i(reset),
    .tick_o (tick)
  );

  assign any_low     = ~&sync2_q;
  assign hit_row     = first_low_row(sync2_q);
  assign latched_low = ~sync2_q[row_q];
  assign col_next    = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
  assign cnt_inc     = cnt_q + CNT_W'(1);

  always_comb begin
    unique case (col_q)
      2'd1:    col_n = 3'b101;
      2'd2:    col_n = 3'b011;
      default: col_n = 3'b110;
    endcase
  end

  assign key_code     = key_code_q;
  assign key_valid    = key_valid_q;
  assign key_release  = key_release_q;
  assign key_pressed  = key_pressed_q;
  assign star_pressed = star_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= 4'hF;
      sync2_q       <= 4'hF;
      state_q       <= SCAN;
      col_q         <= 2'd0;
      row_q         <= 2'd0;
      cnt_q         <= '0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_pressed_q <= 1'b0;
      star_q        <= 1'b0;
    end else begin
      sync1_q       <= row_n;
      sync2_q       <= sync1_q;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      star_q        <= key_pressed_q && (key_code_q == KEY_STAR);

      // The column stays frozen from latch until release so only the
      // latched key can be observed; other keys are ignored while held.
      if (tick) begin
        unique case (state_q)
          SCAN: begin
            if (!any_low) begin
              col_q <= col_next;
            end else begin
              row_q <= hit_row;
              if (SINGLE_SCAN) begin
                key_code_q    <= key_lookup(hit_row, col_q);
                key_valid_q   <= 1'b1;
                key_pressed_q <= 1'b1;
                cnt_q         <= '0;
                state_q       <= HELD;
              end else begin
                cnt_q   <= CNT_W'(1);
                state_q <= DEBOUNCE;
              end
            end
          end

          DEBOUNCE: begin
            if (latched_low) begin
              if (cnt_inc == DEB_MAX) begin
                key_code_q    <= key_lookup(row_q, col_q);
                key_valid_q   <= 1'b1;
                key_pressed_q <= 1'b1;
                cnt_q         <= '0;
                state_q       <= HELD;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q   <= '0;
              col_q   <= col_next;
              state_q <= SCAN;
            end
          end

          HELD: begin
            if (!latched_low) begin
              if (SINGLE_SCAN) begin
                key_pressed_q <= 1'b0;
                key_release_q <= 1'b1;
                cnt_q         <= '0;
                col_q         <= col_next;
                state_q       <= SCAN;
              end else begin
                cnt_q   <= CNT_W'(1);
                state_q <= RELEASE;
              end
            end
          end

          RELEASE: begin
            if (latched_low) begin
              cnt_q   <= '0;
              state_q <= HELD;
            end else if (cnt_inc == DEB_MAX) begin
              key_pressed_q <= 1'b0;
              key_release_q <= 1'b1;
              cnt_q         <= '0;
              col_q         <= col_next;
              state_q       <= SCAN;
            end else begin
              cnt_q <= cnt_inc;
            end
          end

          default: state_q <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows from the
// column strobes; random key sessions are scored against key-level rules.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_pressed;
  logic       star_pressed;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_release (key_release),
    .key_pressed (key_pressed),
    .star_pressed(star_pressed)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Physical keypad: the pressed key shorts its row to its column while that
  // column is driven low; force_high models a contact bounce opening.
  logic       pressed    = 1'b0;
  logic       force_high = 1'b0;
  logic [1:0] kr = 2'd0;
  logic [1:0] kc = 2'd0;

  always_comb begin
    row_n = 4'hF;
    if (pressed && !force_high && (col_n[kc] == 1'b0)) row_n[kr] = 1'b0;
  end

  function automatic void key_pos(input int k, output logic [1:0] r, output logic [1:0] c);
    if (k >= 1 && k <= 9) begin
      r = 2'((k - 1) / 3);
      c = 2'((k - 1) % 3);
    end else if (k == 0) begin
      r = 2'd3; c = 2'd1;
    end else if (k == 10) begin
      r = 2'd3; c = 2'd0;
    end else begin
      r = 2'd3; c = 2'd2;
    end
  endfunction

  function automatic logic [1:0] col_idx(input logic [2:0] c);
    case (c)
      3'b110:  return 2'd0;
      3'b101:  return 2'd1;
      3'b011:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Event monitor: counts strobes and checks the per-cycle level rules.
  int         n_valid  = 0;
  int         n_rel    = 0;
  logic [3:0] valid_code = 4'd0;
  logic [1:0] rel_col  = 2'd0;
  logic       kp_model = 1'b0;
  logic       star_src = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      kp_model = 1'b0;
      star_src = 1'b0;
    end else begin
      if (key_valid) begin
        n_valid++;
        valid_code = key_code;
        kp_model = 1'b1;
      end
      if (key_release) begin
        n_rel++;
        rel_col = col_idx(col_n);
        kp_model = 1'b0;
      end
      check_eq("pressed_level", 32'(key_pressed), 32'(kp_model));
      check_eq("star_latency", 32'(star_pressed), 32'(star_src));
      check_eq("col_onehot", 32'(col_idx(col_n) != 2'd3), 32'd1);
      star_src = key_pressed && (key_code == 4'hA);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_evt(input bit rel, input int base, input int bound, input string tag);
    int i;
    i = 0;
    while (((rel ? n_rel : n_valid) == base) && i < bound) begin
      step(1);
      i++;
    end
    check_eq(tag, 32'((rel ? n_rel : n_valid) != base), 32'd1);
  endtask

  task automatic press_release(input int k, input int hold, input int gap);
    int v0;
    int r0;
    logic [3:0] code;
    logic [1:0] exp_col;
    code = 4'(k);
    key_pos(k, kr, kc);
    exp_col = (kc == 2'd2) ? 2'd0 : kc + 2'd1;
    v0 = n_valid;
    r0 = n_rel;
    pressed = 1'b1;
    wait_evt(1'b0, v0, 40, "press_seen");
    check_eq("press_code", 32'(valid_code), 32'(code));
    check_eq("code_out", 32'(key_code), 32'(code));
    step(hold);
    check_eq("one_valid", 32'(n_valid - v0), 32'd1);
    check_eq("no_early_rel", 32'(n_rel - r0), 32'd0);
    check_eq("held_level", 32'(key_pressed), 32'd1);
    check_eq("star_level", 32'(star_pressed), 32'(code == 4'hA));
    pressed = 1'b0;
    wait_evt(1'b1, r0, 30, "release_seen");
    check_eq("rel_level", 32'(key_pressed), 32'd0);
    check_eq("code_kept", 32'(key_code), 32'(code));
    check_eq("rel_next_col", 32'(rel_col), 32'(exp_col));
    step(2);
    check_eq("star_clear", 32'(star_pressed), 32'd0);
    check_eq("one_rel", 32'(n_rel - r0), 32'd1);
    step(gap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int r0;
    logic [1:0] c0;
    int i;

    reset = 1'b1;
    step(3);
    check_eq("rst_col", 32'(col_n), 32'(3'b110));
    check_eq("rst_code", 32'(key_code), 32'd0);
    check_eq("rst_valid", 32'(key_valid), 32'd0);
    check_eq("rst_release", 32'(key_release), 32'd0);
    check_eq("rst_pressed", 32'(key_pressed), 32'd0);
    check_eq("rst_star", 32'(star_pressed), 32'd0);

    // Idle scanning: column index is floor(cycles/SD) mod 3 after reset.
    @(posedge clk);
    #1 reset = 1'b0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      #1;
      check_eq("idle_col", 32'(col_idx(col_n)), 32'((j / SD) % 3));
    end
    check_eq("idle_no_valid", 32'(n_valid), 32'd0);

    press_release(2, 12, 5);
    press_release(10, 15, 7);
    for (int n = 0; n < 10; n++) begin
      press_release(int'($urandom_range(0, 11)), int'($urandom_range(5, 30)),
                    int'($urandom_range(0, 12)));
    end

    // Bounce while debouncing: pressed only across one tick right after a
    // column change, so it is latched and then abandoned.
    c0 = col_idx(col_n);
    i = 0;
    while (col_idx(col_n) == c0 && i < 3 * SD) begin
      step(1);
      i++;
    end
    kc = col_idx(col_n);
    kr = 2'($urandom_range(0, 2));
    v0 = n_valid;
    pressed = 1'b1;
    step(SD);
    pressed = 1'b0;
    step(6 * SD);
    check_eq("bounce_dbn_valid", 32'(n_valid - v0), 32'd0);
    check_eq("bounce_dbn_level", 32'(key_pressed), 32'd0);
    c0 = col_idx(col_n);
    i = 0;
    while (col_idx(col_n) == c0 && i < 4 * SD) begin
      step(1);
      i++;
    end
    check_eq("bounce_dbn_scan", 32'(col_idx(col_n) != c0), 32'd1);

    // Bounce while held: one tick of open contact must not release.
    key_pos(7, kr, kc);
    v0 = n_valid;
    r0 = n_rel;
    pressed = 1'b1;
    wait_evt(1'b0, v0, 40, "held_bounce_press");
    step(5);
    force_high = 1'b1;
    step(SD);
    force_high = 1'b0;
    step(5 * SD);
    check_eq("held_bounce_norel", 32'(n_rel - r0), 32'd0);
    check_eq("held_bounce_level", 32'(key_pressed), 32'd1);
    pressed = 1'b0;
    wait_evt(1'b1, r0, 30, "held_bounce_rel");
    step(8);

    // Reset while key 5 is held, then re-acquisition after reset.
    key_pos(5, kr, kc);
    v0 = n_valid;
    pressed = 1'b1;
    wait_evt(1'b0, v0, 40, "pre_reset_press");
    check_eq("pre_reset_code", 32'(key_code), 32'd5);
    step(6);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_col", 32'(col_n), 32'(3'b110));
    check_eq("mid_rst_code", 32'(key_code), 32'd0);
    check_eq("mid_rst_valid", 32'(key_valid), 32'd0);
    check_eq("mid_rst_release", 32'(key_release), 32'd0);
    check_eq("mid_rst_pressed", 32'(key_pressed), 32'd0);
    check_eq("mid_rst_star", 32'(star_pressed), 32'd0);
    step(2);
    r0 = n_rel;
    reset = 1'b0;
    v0 = n_valid;
    wait_evt(1'b0, v0, 40, "reacquire_press");
    check_eq("reacquire_code", 32'(valid_code), 32'd5);
    check_eq("reacquire_norel", 32'(n_rel - r0), 32'd0);
    pressed = 1'b0;
    wait_evt(1'b1, r0, 30, "reacquire_rel");
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
